// File: rtl/gun_fire_controller.sv
// gun_fire_controller: rate-limited fire control with an overheat lockout.
// Turns the fire button into bullet spawn requests and drives shoot, overheat, heat_bar and shots_fired.
//
// Ports:
//   clock, reset   : clock, synchronous active-high reset
//   fire_btn       : raw asynchronous fire button
//   heat           : 4-bit heat level from the cooldown handler
//   bullet_ack     : spawn accepted by the projectile manager
//   shoot          : level sent back to the cooldown handler
//   bullet_req     : spawn request, held until acknowledged
//   overheat       : high while the gun is locked out
//   heat_bar       : thermometer code, bit i = (heat > i)
//   shots_fired    : acknowledged shot count, wraps modulo 256
module gun_fire_controller #(
  parameter int unsigned SHOT_INTERVAL = 12_500_000,
  parameter int unsigned HEAT_MAX      = 15,
  parameter int unsigned HEAT_RESUME   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fire_btn,
  input  logic [3:0]  heat,
  input  logic        bullet_ack,
  output logic        shoot,
  output logic        bullet_req,
  output logic        overheat,
  output logic [14:0] heat_bar,
  output logic [7:0]  shots_fired
);

  localparam int unsigned CW =
    (SHOT_INTERVAL > 1) ? $clog2(SHOT_INTERVAL) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(SHOT_INTERVAL - 1);

  typedef enum logic [1:0] {
    READY,
    REQ,
    GAP,
    LOCKED
  } state_t;

  state_t        state_q, state_d;
  logic          fire_meta_q;
  logic          fire_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    shots_q, shots_d;
  logic          shoot_q, shoot_d;
  logic          req_q, req_d;
  logic          ovh_q, ovh_d;
  logic [14:0]   bar_q, bar_d;
  logic          hot;
  logic          cool;

  assign hot  = (32'(heat) >= HEAT_MAX);
  assign cool = (32'(heat) <= HEAT_RESUME);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shots_d = shots_q;
    unique case (state_q)
      READY: begin
        if (hot) begin
          state_d = LOCKED;
        end else if (fire_s_q) begin
          state_d = REQ;
        end
      end
      REQ: begin
        // The shot always completes once requested.
        if (bullet_ack) begin
          shots_d = shots_q + 8'd1;
          cnt_d   = CNT_LOAD;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (hot) begin
          state_d = LOCKED;
        end else if (fire_s_q) begin
          state_d = REQ;
        end else begin
          state_d = READY;
        end
      end
      LOCKED: begin
        // Held fire keeps the lock even when cool.
        if (cool && !fire_s_q) begin
          state_d = READY;
        end
      end
      default: state_d = READY;
    endcase
  end

  always_comb begin
    req_d   = (state_d == REQ);
    ovh_d   = (state_d == LOCKED);
    // Shoot drops during lockout so heat can decay.
    shoot_d = fire_s_q && (state_d != LOCKED);
    bar_d   = '0;
    for (int i = 0; i < 15; i++) begin
      bar_d[i] = (heat > 4'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= READY;
      fire_meta_q <= 1'b0;
      fire_s_q    <= 1'b0;
      cnt_q       <= '0;
      shots_q     <= '0;
      shoot_q     <= 1'b0;
      req_q       <= 1'b0;
      ovh_q       <= 1'b0;
      bar_q       <= '0;
    end else begin
      state_q     <= state_d;
      fire_meta_q <= fire_btn;
      fire_s_q    <= fire_meta_q;
      cnt_q       <= cnt_d;
      shots_q     <= shots_d;
      shoot_q     <= shoot_d;
      req_q       <= req_d;
      ovh_q       <= ovh_d;
      bar_q       <= bar_d;
    end
  end

  assign shoot       = shoot_q;
  assign bullet_req  = req_q;
  assign overheat    = ovh_q;
  assign heat_bar    = bar_q;
  assign shots_fired = shots_q;

endmodule
